return_stack: RTL and testbench

//  Parametrised hardware return-address stack for the CPU PC unit: stores return addresses for call/interrupt, supplies them for ret.

---
 rtl/return_stack_pkg.sv | 25 ++
 rtl/return_stack_if.sv | 33 +++
 rtl/return_stack_mem.sv | 26 ++
 rtl/return_stack.sv | 122 ++++++++++++
 tb/tb_return_stack.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/return_stack_pkg.sv
// Shared sizing defaults and operation decode for the return-address stack.
// CPU_ADDR_W / RSTACK_DEPTH are the defaults the PC unit instantiates with.
package return_stack_pkg;

  localparam int CPU_ADDR_W   = 32;
  localparam int RSTACK_DEPTH = 16;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } stack_op_e;

  // push+pop together means "replace the top", not two separate operations
  function automatic stack_op_e decode_op(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return OP_PUSH;
      2'b01:   return OP_POP;
      2'b11:   return OP_REPLACE;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/return_stack_if.sv
// Control/data bundle between the PC next-address logic (master) and the
// return-address stack (slave).
interface return_stack_if
  import return_stack_pkg::*;
#(
  parameter int WIDTH = CPU_ADDR_W,
  parameter int DEPTH = RSTACK_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
);

  logic             en;
  logic             flush;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output en, flush, push, pop, data_in,
    input  data_out, count, empty, full, overflow, underflow
  );

  modport slave (
    input  en, flush, push, pop, data_in,
    output data_out, count, empty, full, overflow, underflow
  );

endinterface

// File: rtl/return_stack_mem.sv
// DEPTH x WIDTH register file for the return stack: one synchronous write
// port, one asynchronous read port. Contents are deliberately not reset.
module return_stack_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/return_stack.sv
// Parametrised circular return-address stack: pointer/count control, registered
// top-of-stack and, when RSTACK_GUARD_EN is defined, sticky overflow/underflow flags.
module return_stack
  import return_stack_pkg::*;
#(
  parameter int WIDTH = CPU_ADDR_W,
  parameter int DEPTH = RSTACK_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           rst,
  return_stack_if.slave bus
);

  localparam logic [PTR_W:0] COUNT_MAX = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W:0]   count_q;
  logic [WIDTH-1:0] data_q;
  logic [PTR_W-1:0] wr_addr;
  logic [PTR_W-1:0] rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             mem_we;
  logic             full_w;
  logic             empty_w;
  stack_op_e        op;

  assign op      = decode_op(bus.push, bus.pop);
  assign full_w  = (count_q == COUNT_MAX);
  assign empty_w = (count_q == '0);

  // Replace writes over the current top; a plain push writes the slot above it.
  assign wr_addr = (op == OP_REPLACE) ? ptr : ptr + 1'b1;
  assign rd_addr = ptr - 1'b1;
  assign mem_we  = ~rst & bus.en & ~bus.flush & ((op == OP_PUSH) | (op == OP_REPLACE));

  return_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .wr_addr (wr_addr),
    .wr_data (bus.data_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // A push when full wraps over the oldest entry, so count saturates at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      count_q <= '0;
      data_q  <= '0;
    end else if (bus.en) begin
      if (bus.flush) begin
        ptr     <= '0;
        count_q <= '0;
        data_q  <= '0;
      end else begin
        case (op)
          OP_PUSH: begin
            ptr    <= ptr + 1'b1;
            data_q <= bus.data_in;
            if (!full_w) begin
              count_q <= count_q + 1'b1;
            end
          end
          OP_POP: begin
            if (!empty_w) begin
              ptr     <= ptr - 1'b1;
              data_q  <= rd_data;
              count_q <= count_q - 1'b1;
            end
          end
          OP_REPLACE: begin
            data_q <= bus.data_in;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.data_out = data_q;
  assign bus.count    = count_q;
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;

`ifdef RSTACK_GUARD_EN
  logic overflow_q;
  logic underflow_q;

  // Flags latch on a lost push or an ignored pop and clear only on rst or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.en) begin
      if (bus.flush) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else begin
        if ((op == OP_PUSH) && full_w) begin
          overflow_q <= 1'b1;
        end
        if ((op == OP_POP) && empty_w) begin
          underflow_q <= 1'b1;
        end
      end
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_return_stack.sv
// Directed self-checking bench for return_stack at DEPTH=4, WIDTH=32; flag
// expectations follow whether RSTACK_GUARD_EN is defined for the build.
module tb_return_stack;

`ifdef RSTACK_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  return_stack_if #(.WIDTH(32), .DEPTH(4)) bus ();

  return_stack #(
    .WIDTH (32),
    .DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic p, input logic q, input logic [31:0] d);
    bus.push    = p;
    bus.pop     = q;
    bus.data_in = d;
    tick();
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.count !== 3'd0) $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); else passed++;
    checks++; if (bus.data_out !== 32'h0) $display("[TB] FAIL reset_data: got %h expected 0", bus.data_out); else passed++;
    checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) $display("[TB] FAIL reset_empty_full: got %b%b expected 10", bus.empty, bus.full); else passed++;
    checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) $display("[TB] FAIL reset_flags: got %b%b expected 00", bus.overflow, bus.underflow); else passed++;
    rst = 1'b0;
    bus.en = 1'b1;
    tick();
  endtask

  task automatic test_push_pop();
    do_op(1'b1, 1'b0, 32'h100);
    do_op(1'b1, 1'b0, 32'h200);
    do_op(1'b1, 1'b0, 32'h300);
    checks++; if (bus.data_out !== 32'h300 || bus.count !== 3'd3) $display("[TB] FAIL push3: got %h/%0d expected 300/3", bus.data_out, bus.count); else passed++;
    do_op(1'b0, 1'b1, 32'h0);
    checks++; if (bus.data_out !== 32'h200 || bus.count !== 3'd2) $display("[TB] FAIL pop1: got %h/%0d expected 200/2", bus.data_out, bus.count); else passed++;
    do_op(1'b0, 1'b1, 32'h0);
    checks++; if (bus.data_out !== 32'h100 || bus.count !== 3'd1) $display("[TB] FAIL pop2: got %h/%0d expected 100/1", bus.data_out, bus.count); else passed++;
    do_op(1'b0, 1'b1, 32'h0);
    checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1) $display("[TB] FAIL pop3_empty: got %0d/%b expected 0/1", bus.count, bus.empty); else passed++;
  endtask

  task automatic test_overflow();
    logic [31:0] vals [5];
    vals = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE};
    do_flush();
    for (int i = 0; i < 4; i++) do_op(1'b1, 1'b0, vals[i]);
    checks++; if (bus.count !== 3'd4 || bus.full !== 1'b1) $display("[TB] FAIL fill_count_full: got %0d/%b expected 4/1", bus.count, bus.full); else passed++;
    checks++; if (bus.overflow !== 1'b0 || bus.data_out !== 32'hD) $display("[TB] FAIL fill_noovf: got %b/%h expected 0/d", bus.overflow, bus.data_out); else passed++;
    do_op(1'b1, 1'b0, vals[4]);
    checks++; if (bus.count !== 3'd4 || bus.data_out !== 32'hE) $display("[TB] FAIL wrap_push: got %0d/%h expected 4/e", bus.count, bus.data_out); else passed++;
    checks++; if (bus.overflow !== GUARD) $display("[TB] FAIL overflow_flag: got %b expected %b", bus.overflow, GUARD); else passed++;
    do_op(1'b0, 1'b1, 32'h0);
    checks++; if (bus.data_out !== 32'hD || bus.count !== 3'd3 || bus.full !== 1'b0) $display("[TB] FAIL wrap_pop1: got %h/%0d/%b expected d/3/0", bus.data_out, bus.count, bus.full); else passed++;
    do_op(1'b0, 1'b1, 32'h0);
    checks++; if (bus.data_out !== 32'hC || bus.count !== 3'd2) $display("[TB] FAIL wrap_pop2: got %h/%0d expected c/2", bus.data_out, bus.count); else passed++;
    do_op(1'b0, 1'b1, 32'h0);
    checks++; if (bus.data_out !== 32'hB || bus.count !== 3'd1) $display("[TB] FAIL wrap_pop3: got %h/%0d expected b/1", bus.data_out, bus.count); else passed++;
    do_op(1'b0, 1'b1, 32'h0);
    checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1) $display("[TB] FAIL wrap_pop4_empty: got %0d/%b expected 0/1", bus.count, bus.empty); else passed++;
  endtask

  task automatic test_underflow();
    do_flush();
    checks++; if (bus.overflow !== 1'b0) $display("[TB] FAIL flush_clears_ovf: got %b expected 0", bus.overflow); else passed++;
    do_op(1'b0, 1'b1, 32'h0);
    checks++; if (bus.count !== 3'd0 || bus.data_out !== 32'h0 || bus.empty !== 1'b1) $display("[TB] FAIL pop_empty_hold: got %0d/%h/%b expected 0/0/1", bus.count, bus.data_out, bus.empty); else passed++;
    checks++; if (bus.underflow !== GUARD || bus.overflow !== 1'b0) $display("[TB] FAIL underflow_flag: got %b%b expected %b0", bus.underflow, bus.overflow, GUARD); else passed++;
  endtask

  task automatic test_replace();
    do_flush();
    do_op(1'b1, 1'b0, 32'h10);
    do_op(1'b1, 1'b1, 32'h20);
    checks++; if (bus.data_out !== 32'h20 || bus.count !== 3'd1) $display("[TB] FAIL replace: got %h/%0d expected 20/1", bus.data_out, bus.count); else passed++;
    do_op(1'b0, 1'b1, 32'h0);
    checks++; if (bus.empty !== 1'b1 || bus.count !== 3'd0) $display("[TB] FAIL replace_pop: got %b/%0d expected 1/0", bus.empty, bus.count); else passed++;
    do_op(1'b1, 1'b1, 32'h77);
    checks++; if (bus.data_out !== 32'h77 || bus.count !== 3'd0 || bus.empty !== 1'b1) $display("[TB] FAIL replace_empty: got %h/%0d/%b expected 77/0/1", bus.data_out, bus.count, bus.empty); else passed++;
  endtask

  task automatic test_enable_flush();
    do_flush();
    do_op(1'b0, 1'b1, 32'h0);
    do_op(1'b1, 1'b0, 32'h1);
    do_op(1'b1, 1'b0, 32'h2);
    do_op(1'b1, 1'b0, 32'h3);
    checks++; if (bus.count !== 3'd3 || bus.data_out !== 32'h3 || bus.underflow !== GUARD) $display("[TB] FAIL ef_setup: got %0d/%h/%b expected 3/3/%b", bus.count, bus.data_out, bus.underflow, GUARD); else passed++;
    bus.en = 1'b0;
    do_op(1'b1, 1'b0, 32'h40);
    checks++; if (bus.count !== 3'd3 || bus.data_out !== 32'h3) $display("[TB] FAIL en0_push: got %0d/%h expected 3/3", bus.count, bus.data_out); else passed++;
    do_flush();
    checks++; if (bus.count !== 3'd3 || bus.data_out !== 32'h3 || bus.underflow !== GUARD) $display("[TB] FAIL en0_flush: got %0d/%h/%b expected 3/3/%b", bus.count, bus.data_out, bus.underflow, GUARD); else passed++;
    bus.en = 1'b1;
    bus.flush = 1'b1;
    do_op(1'b1, 1'b0, 32'h99);
    bus.flush = 1'b0;
    checks++; if (bus.count !== 3'd0 || bus.data_out !== 32'h0 || bus.empty !== 1'b1) $display("[TB] FAIL flush_push: got %0d/%h/%b expected 0/0/1", bus.count, bus.data_out, bus.empty); else passed++;
    checks++; if (bus.underflow !== 1'b0 || bus.overflow !== 1'b0) $display("[TB] FAIL flush_flags: got %b%b expected 00", bus.underflow, bus.overflow); else passed++;
  endtask

  task automatic test_async_reset();
    do_flush();
    do_op(1'b1, 1'b0, 32'h11);
    do_op(1'b1, 1'b0, 32'h22);
    checks++; if (bus.count !== 3'd2 || bus.data_out !== 32'h22) $display("[TB] FAIL prereset: got %0d/%h expected 2/22", bus.count, bus.data_out); else passed++;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.count !== 3'd0 || bus.data_out !== 32'h0 || bus.empty !== 1'b1) $display("[TB] FAIL async_reset: got %0d/%h/%b expected 0/0/1", bus.count, bus.data_out, bus.empty); else passed++;
    #1;
    rst = 1'b0;
    do_op(1'b1, 1'b0, 32'h55);
    checks++; if (bus.count !== 3'd1 || bus.data_out !== 32'h55) $display("[TB] FAIL post_reset_push: got %0d/%h expected 1/55", bus.count, bus.data_out); else passed++;
  endtask

  initial begin
    checks      = 0;
    passed      = 0;
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.flush   = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_replace();
    test_enable_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
